// File: rtl/vector_data_access_unit.sv
// Memory-stage sequencer: scalar loads/stores pass straight through to the word memory,
// vector loads/stores are split into LANES word beats while BusyDA stalls the pipeline.
module vector_data_access_unit #(
  parameter int WORD_W = 32,
  parameter int LANES  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MemReadM,
  input  logic                      MemWriteM,
  input  logic                      VecM,
  input  logic [ADDR_W-1:0]         ALUResultM,
  input  logic [WORD_W-1:0]         WriteDataM,
  input  logic [LANES*WORD_W-1:0]   WriteDataVM,
  input  logic [WORD_W-1:0]         mem_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [WORD_W-1:0]         mem_wdata,
  output logic [WORD_W-1:0]         ReadDataM,
  output logic [LANES*WORD_W-1:0]   ReadDataVM,
  output logic                      BusyDA
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} stateT;

  stateT                          state, nextState;
  logic [CNT_W-1:0]               cnt;
  logic [ADDR_W-1:0]              baseAddr;
  logic                           opStore;
  logic [LANES-1:0][WORD_W-1:0]   vecData;
  logic [LANES-1:0][WORD_W-1:0]   readLanes;
  logic                           vreq;

  assign vreq       = VecM & (MemReadM | MemWriteM);
  assign ReadDataM  = mem_rdata;
  assign ReadDataVM = readLanes;

  // Load beats land one cycle late, so lane cnt-1 is captured during ACCESS and the last lane in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      baseAddr  <= '0;
      opStore   <= 1'b0;
      vecData   <= '0;
      readLanes <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (vreq) begin
            baseAddr <= {ALUResultM[ADDR_W-1:2], 2'b00};
            opStore  <= MemWriteM;
            vecData  <= WriteDataVM;
            cnt      <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (!opStore && cnt != '0)
            readLanes[cnt - 1'b1] <= mem_rdata;
        end
        DRAIN: readLanes[LAST] <= mem_rdata;
        default: ;
      endcase
    end
  end

  // A reset arriving mid-store must not let the current beat reach memory.
  always_comb begin
    nextState = state;
    mem_addr  = ALUResultM;
    mem_we    = 1'b0;
    mem_wdata = WriteDataM;
    BusyDA    = 1'b0;
    case (state)
      IDLE: begin
        if (vreq) begin
          BusyDA    = 1'b1;
          nextState = ACCESS;
        end else begin
          mem_we = MemWriteM & ~VecM;
        end
      end
      ACCESS: begin
        BusyDA    = 1'b1;
        mem_addr  = baseAddr + ADDR_W'({cnt, 2'b00});
        mem_we    = opStore & ~rst;
        mem_wdata = vecData[cnt];
        if (cnt == LAST)
          nextState = opStore ? DONE : DRAIN;
      end
      DRAIN: begin
        BusyDA    = 1'b1;
        nextState = DONE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_data_access_unit.sv
// Directed bench for vector_data_access_unit with a small synchronous word memory model
// indexed by address bits [5:2].
module tb_vector_data_access_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         MemReadM, MemWriteM, VecM;
  logic [31:0]  ALUResultM, WriteDataM;
  logic [127:0] WriteDataVM;
  logic [31:0]  mem_rdata;
  logic [31:0]  mem_addr;
  logic         mem_we;
  logic [31:0]  mem_wdata;
  logic [31:0]  ReadDataM;
  logic [127:0] ReadDataVM;
  logic         BusyDA;

  logic [31:0]  mem [0:15];
  int           errors = 0;
  int           checks = 0;

  vector_data_access_unit #(.WORD_W(32), .LANES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .VecM(VecM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WriteDataVM(WriteDataVM),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .ReadDataM(ReadDataM), .ReadDataVM(ReadDataVM), .BusyDA(BusyDA)
  );

  always #5 clk = ~clk;

  // Synchronous memory: write on enable, read data valid one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[5:2]];
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic vec,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [127:0] vdata);
    MemReadM    = rd;
    MemWriteM   = wr;
    VecM        = vec;
    ALUResultM  = addr;
    WriteDataM  = wdata;
    WriteDataVM = vdata;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checks++; if (BusyDA !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", BusyDA); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (ReadDataVM !== 128'h0) begin errors++; $display("[TB] FAIL reset_rdv got=%h exp=0", ReadDataVM); end
    nextCycle();
    rst = 1'b0;
    nextCycle();
  endtask

  task automatic test_scalar;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 128'h0);
    @(negedge clk);
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL sst_addr got=%h exp=00000010", mem_addr); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL sst_we got=%b exp=1", mem_we); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sst_wdata got=%h exp=deadbeef", mem_wdata); end
    checks++; if (BusyDA !== 1'b0) begin errors++; $display("[TB] FAIL sst_busy got=%b exp=0", BusyDA); end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 128'h0);
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || BusyDA !== 1'b0) begin errors++; $display("[TB] FAIL sld_ctrl got we=%b busy=%b exp=0/0", mem_we, BusyDA); end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
    @(negedge clk);
    checks++; if (ReadDataM !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sld_data got=%h exp=deadbeef", ReadDataM); end
    nextCycle();
  endtask

  task automatic test_vector_store;
    logic [127:0] vd;
    vd = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h20, 32'h0, vd);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (BusyDA !== logic'(c < 5)) begin errors++; $display("[TB] FAIL vst_busy c=%0d got=%b exp=%b", c, BusyDA, c < 5); end
      checks++; if (mem_we !== logic'(c >= 1 && c <= 4)) begin errors++; $display("[TB] FAIL vst_we c=%0d got=%b", c, mem_we); end
      if (c >= 1 && c <= 4) begin
        checks++; if (mem_addr !== 32'h20 + 32'(4 * (c - 1))) begin errors++; $display("[TB] FAIL vst_addr c=%0d got=%h", c, mem_addr); end
        checks++; if (mem_wdata !== 32'h11111111 * 32'(c - 1)) begin errors++; $display("[TB] FAIL vst_wdata c=%0d got=%h", c, mem_wdata); end
      end
      nextCycle();
      if (c == 5) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem[8 + k] !== 32'h11111111 * 32'(k)) begin errors++; $display("[TB] FAIL vst_mem k=%0d got=%h", k, mem[8 + k]); end
    end
  endtask

  task automatic test_vector_load;
    for (int k = 0; k < 4; k++) mem[8 + k] = 32'hA0 + 32'(k);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h23, 32'h0, 128'h0);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      checks++; if (BusyDA !== logic'(c < 6)) begin errors++; $display("[TB] FAIL vld_busy c=%0d got=%b exp=%b", c, BusyDA, c < 6); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL vld_we c=%0d got=%b exp=0", c, mem_we); end
      if (c >= 1 && c <= 4) begin
        checks++; if (mem_addr !== 32'h20 + 32'(4 * (c - 1))) begin errors++; $display("[TB] FAIL vld_addr c=%0d got=%h", c, mem_addr); end
      end
      if (c == 6) begin
        checks++; if (ReadDataVM !== 128'h000000A3_000000A2_000000A1_000000A0) begin errors++; $display("[TB] FAIL vld_data got=%h", ReadDataVM); end
      end
      nextCycle();
      if (c == 6) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
    end
    @(negedge clk);
    checks++; if (ReadDataVM !== 128'h000000A3_000000A2_000000A1_000000A0) begin errors++; $display("[TB] FAIL vld_hold got=%h", ReadDataVM); end
    nextCycle();
  endtask

  task automatic test_address_wrap;
    logic [31:0] expAddr [4];
    expAddr = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    mem[14] = 32'hB0; mem[15] = 32'hB1; mem[0] = 32'hB2; mem[1] = 32'hB3;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFFFFF8, 32'h0, 128'h0);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        checks++; if (mem_addr !== expAddr[c - 1]) begin errors++; $display("[TB] FAIL wrap_addr c=%0d got=%h exp=%h", c, mem_addr, expAddr[c - 1]); end
      end
      if (c == 6) begin
        checks++; if (ReadDataVM !== 128'h000000B3_000000B2_000000B1_000000B0) begin errors++; $display("[TB] FAIL wrap_data got=%h", ReadDataVM); end
      end
      nextCycle();
      if (c == 6) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] vd;
    logic         busyLog [13];
    vd = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h30, 32'h0, vd);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      busyLog[c] = BusyDA;
      if (c == 5) begin
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_we got=%b exp=0", mem_we); end
      end
      if (c == 12) begin
        checks++; if (ReadDataVM !== vd) begin errors++; $display("[TB] FAIL b2b_data got=%h exp=%h", ReadDataVM, vd); end
      end
      nextCycle();
      if (c == 5) applyStimulus(1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 128'h0);
      if (c == 12) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
    end
    for (int c = 0; c <= 12; c++) begin
      checks++; if (busyLog[c] !== logic'(c != 5 && c != 12)) begin errors++; $display("[TB] FAIL b2b_busy c=%0d got=%b exp=%b", c, busyLog[c], c != 5 && c != 12); end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 4; k++) mem[k] = 32'h5A5A5A5A;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h0,
                  {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
    @(negedge clk);
    checks++; if (BusyDA !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy got=%b exp=0", BusyDA); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rmid_we got=%b exp=0", mem_we); end
    checks++; if (ReadDataVM !== 128'h0) begin errors++; $display("[TB] FAIL rmid_rdv got=%h exp=0", ReadDataVM); end
    nextCycle();
    nextCycle();
    checks++; if (mem[0] !== 32'h11111111) begin errors++; $display("[TB] FAIL rmid_beat0 got=%h exp=11111111", mem[0]); end
    for (int k = 1; k < 4; k++) begin
      checks++; if (mem[k] !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL rmid_nowrite k=%0d got=%h exp=5a5a5a5a", k, mem[k]); end
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 32'h0;
    test_reset();
    test_scalar();
    test_vector_store();
    test_vector_load();
    test_address_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
